// File: rtl/pc_sequencer.sv
// Program counter sequencer with increment, absolute/relative jump and a
// bounded LIFO return stack for CALL/RET. All outputs come from registers.
module pc_sequencer #(
  parameter int WIDTH       = 5,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VAL   = 0,
  localparam int SPW        = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] pc,
  output logic [SPW-1:0]   sp,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             err,
  output logic             wrap
);

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_LOAD   = 3'b010,
    OP_REL    = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_CLRERR = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  logic [STACK_DEPTH-1:0][WIDTH-1:0] stack;
  logic [WIDTH-1:0] pc_nxt, pc_inc;
  logic [SPW-1:0]   sp_nxt, sp_m1;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             err_nxt, wrap_nxt, push;

  assign stk_full  = (sp == SPW'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign pc_inc    = pc + WIDTH'(1);
  assign sp_m1     = sp - SPW'(1);
  assign wr_idx    = sp[IW-1:0];
  assign rd_idx    = sp_m1[IW-1:0];

  always_comb begin
    pc_nxt   = pc;
    sp_nxt   = sp;
    err_nxt  = err;
    wrap_nxt = 1'b0;
    push     = 1'b0;
    if (en) begin
      case (op_e'(op))
        OP_INC: begin
          pc_nxt   = pc_inc;
          wrap_nxt = &pc;
        end
        OP_LOAD: pc_nxt = data;
        // Same-width add gives the sign-extended, truncated result directly.
        OP_REL:  pc_nxt = pc + data;
        OP_CALL: begin
          if (!stk_full) begin
            push   = 1'b1;
            sp_nxt = sp + SPW'(1);
            pc_nxt = data;
          end else begin
            err_nxt = 1'b1;
          end
        end
        OP_RET: begin
          if (!stk_empty) begin
            pc_nxt = stack[rd_idx];
            sp_nxt = sp_m1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        OP_CLRERR: err_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pc   <= WIDTH'(RESET_VAL);
      sp   <= '0;
      err  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      pc   <= pc_nxt;
      sp   <= sp_nxt;
      err  <= err_nxt;
      wrap <= wrap_nxt;
    end
  end

  // Stack body needs no reset: sp=0 makes every entry unreachable.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default parameters) with hand-computed
// expected pc/sp/err/wrap after each operation.
module tb_pc_sequencer;
  localparam int WIDTH = 5;
  localparam int SPW   = 3;

  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, LOAD = 3'b010,
                         REL = 3'b011, CALL = 3'b100, RET = 3'b101,
                         CLRERR = 3'b110, RSVD = 3'b111;

  logic             clk = 1'b0;
  logic             rst_;
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] pc;
  logic [SPW-1:0]   sp;
  logic             stk_full, stk_empty, err, wrap;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer dut (
    .clk(clk), .rst_(rst_), .en(en), .op(op), .data(data),
    .pc(pc), .sp(sp), .stk_full(stk_full), .stk_empty(stk_empty),
    .err(err), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input int epc, input int esp,
                           input int eerr, input int ewrap);
    chk({tag, ".pc"},    int'(pc),        epc);
    chk({tag, ".sp"},    int'(sp),        esp);
    chk({tag, ".err"},   int'(err),       eerr);
    chk({tag, ".wrap"},  int'(wrap),      ewrap);
    chk({tag, ".full"},  int'(stk_full),  (esp == 4) ? 1 : 0);
    chk({tag, ".empty"}, int'(stk_empty), (esp == 0) ? 1 : 0);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [2:0] o, input int d, input logic e = 1'b1);
    op   = o;
    data = WIDTH'(d);
    en   = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_ = 1'b0; en = 1'b0; op = HOLD; data = '0;
    #3;
    expect_st("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_ = 1'b1;

    step(INC, 0);  expect_st("inc1", 1, 0, 0, 0);
    step(INC, 0);  expect_st("inc2", 2, 0, 0, 0);
    step(INC, 0);  expect_st("inc3", 3, 0, 0, 0);

    step(LOAD, 31); expect_st("load31", 31, 0, 0, 0);
    step(INC, 0);   expect_st("incwrap", 0, 0, 0, 1);
    step(INC, 0);   expect_st("incafterwrap", 1, 0, 0, 0);

    step(LOAD, 4);          expect_st("load4", 4, 0, 0, 0);
    step(REL, 5'b11110);    expect_st("relneg", 2, 0, 0, 0);
    step(REL, 5'b00011);    expect_st("relpos", 5, 0, 0, 0);
    step(LOAD, 30);         expect_st("load30", 30, 0, 0, 0);
    step(REL, 3);           expect_st("relwrap", 1, 0, 0, 0);
    step(LOAD, 1);
    step(REL, 5'b11110);    expect_st("relunder", 31, 0, 0, 0);

    step(LOAD, 3);
    step(CALL, 10); expect_st("call1", 10, 1, 0, 0);
    step(CALL, 20); expect_st("call2", 20, 2, 0, 0);
    step(CALL, 7);  expect_st("call3", 7, 3, 0, 0);
    step(CALL, 12); expect_st("call4", 12, 4, 0, 0);
    step(CALL, 9);  expect_st("callfull", 12, 4, 1, 0);
    step(RET, 0);   expect_st("ret1", 8, 3, 1, 0);
    step(RET, 0);   expect_st("ret2", 21, 2, 1, 0);
    step(RET, 0);   expect_st("ret3", 11, 1, 1, 0);
    step(RET, 0);   expect_st("ret4", 4, 0, 1, 0);

    step(CLRERR, 0); expect_st("clr1", 4, 0, 0, 0);
    step(RET, 0);    expect_st("retempty", 4, 0, 1, 0);
    step(INC, 0);    expect_st("errsticky", 5, 0, 1, 0);
    step(RSVD, 9);   expect_st("rsvd", 5, 0, 1, 0);
    step(CLRERR, 0); expect_st("clr2", 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(INC, 0, 1'b0); expect_st("hold", 5, 0, 0, 0);
    end
    step(HOLD, 0);  expect_st("opnop", 5, 0, 0, 0);

    step(LOAD, 31);
    step(INC, 0, 1'b0);  expect_st("holdnowrap", 31, 0, 0, 0);
    step(CALL, 9);       expect_st("callret.c", 9, 1, 0, 0);
    step(RET, 0);        expect_st("callret.r", 0, 0, 0, 0);

    step(CALL, 5);  expect_st("pre.c1", 5, 1, 0, 0);
    step(CALL, 17); expect_st("pre.c2", 17, 2, 0, 0);
    step(RET, 0, 1'b0);
    #2 rst_ = 1'b0;
    #1 expect_st("asyncrst", 0, 0, 0, 0);
    #1 rst_ = 1'b1;
    @(negedge clk);
    step(RET, 0);   expect_st("retafterrst", 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
